// File: rtl/copro_fifo_link_if.sv
// rtl/copro_fifo_link_if.sv - Avalon FIFO, accelerator stream and status signals of copro_fifo_link
interface copro_fifo_link_if;
  logic        fifo_to_copro_out_read;
  logic [31:0] fifo_to_copro_out_readdata;
  logic        fifo_to_copro_out_waitrequest;
  logic        fifo_to_hps_in_write;
  logic [31:0] fifo_to_hps_in_writedata;
  logic        fifo_to_hps_in_waitrequest;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_opcode;
  logic [7:0]  cmd_tag;
  logic [15:0] cmd_len;
  logic        pl_valid;
  logic        pl_ready;
  logic [31:0] pl_data;
  logic        pl_last;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_last;
  logic [31:0] status;

  modport master (
    output fifo_to_copro_out_read,
    input  fifo_to_copro_out_readdata, fifo_to_copro_out_waitrequest,
    output fifo_to_hps_in_write, fifo_to_hps_in_writedata,
    input  fifo_to_hps_in_waitrequest,
    output cmd_valid, cmd_opcode, cmd_tag, cmd_len,
    input  cmd_ready,
    output pl_valid, pl_data, pl_last,
    input  pl_ready,
    input  res_valid, res_data, res_last,
    output res_ready,
    output status
  );

  modport slave (
    input  fifo_to_copro_out_read,
    output fifo_to_copro_out_readdata, fifo_to_copro_out_waitrequest,
    input  fifo_to_hps_in_write, fifo_to_hps_in_writedata,
    output fifo_to_hps_in_waitrequest,
    input  cmd_valid, cmd_opcode, cmd_tag, cmd_len,
    output cmd_ready,
    input  pl_valid, pl_data, pl_last,
    output pl_ready,
    output res_valid, res_data, res_last,
    input  res_ready,
    input  status
  );
endinterface

// File: rtl/copro_fifo_link.sv
// rtl/copro_fifo_link.sv - coprocessor endpoint of the HPS/FPGA FIFO pair (optional watchdog: COPRO_LINK_TIMEOUT_EN)
// RX parses header+payload from one Avalon FIFO; TX writes results plus a trailer word to the other.
module copro_fifo_link #(
  parameter logic [15:0] MAX_LEN        = 16'd4096,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter logic [7:0]  TRAILER_MAGIC  = 8'hA5
) (
  input logic          clk,
  input logic          reset,
  copro_fifo_link_if.master bus
);
  typedef enum logic [1:0] {R_HDR = 2'd0, R_CMD = 2'd1, R_PAY = 2'd2, R_DROP = 2'd3} rx_state_t;
  typedef enum logic {T_DATA = 1'b0, T_TRAIL = 1'b1} tx_state_t;

  rx_state_t   rx_state, rx_next;
  tx_state_t   tx_state, tx_next;
  logic [7:0]  opcode_q, tag_q, last_tag, tx_tag, cmd_cnt;
  logic [15:0] len_q, remaining, tx_count;
  logic [31:0] pl_data_q, writedata_q;
  logic        pl_valid_q, pl_last_q, write_q, trail_issued;
  logic        bad_len, timeout_flag, timeout_hit;
  logic        rd_req, rd_done, wr_done, hdr_bad, cmd_fire, pl_fire, res_fire;

  assign rd_done  = bus.fifo_to_copro_out_read & ~bus.fifo_to_copro_out_waitrequest;
  assign wr_done  = write_q & ~bus.fifo_to_hps_in_waitrequest;
  assign hdr_bad  = bus.fifo_to_copro_out_readdata[15:0] > MAX_LEN;
  assign cmd_fire = (rx_state == R_CMD) & bus.cmd_ready;
  assign pl_fire  = pl_valid_q & bus.pl_ready;
  assign res_fire = bus.res_valid & bus.res_ready;

`ifdef COPRO_LINK_TIMEOUT_EN
  logic [31:0] wd_cnt;
  logic        wd_active;
  assign wd_active   = (rx_state == R_PAY) || (rx_state == R_DROP);
  assign timeout_hit = wd_active && (wd_cnt >= TIMEOUT_CYCLES);

  // Counts only consecutive stalled read cycles; any gap restarts the count.
  always_ff @(posedge clk) begin
    if (reset || !wd_active || !(bus.fifo_to_copro_out_read && bus.fifo_to_copro_out_waitrequest))
      wd_cnt <= 32'd0;
    else
      wd_cnt <= wd_cnt + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)            timeout_flag <= 1'b0;
    else if (timeout_hit) timeout_flag <= 1'b1;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit  = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= R_HDR;
      tx_state <= T_DATA;
    end else begin
      rx_state <= rx_next;
      tx_state <= tx_next;
    end
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      R_HDR:   if (rd_done) rx_next = hdr_bad ? R_DROP : R_CMD;
      R_CMD:   if (cmd_fire) rx_next = (len_q == 16'd0) ? R_HDR : R_PAY;
      R_PAY:   if ((pl_fire && pl_last_q) || timeout_hit) rx_next = R_HDR;
      R_DROP:  if ((rd_done && remaining == 16'd1) || timeout_hit) rx_next = R_HDR;
      default: rx_next = R_HDR;
    endcase
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      T_DATA:  if (res_fire && bus.res_last) tx_next = T_TRAIL;
      T_TRAIL: if (trail_issued && wr_done) tx_next = T_DATA;
      default: tx_next = T_DATA;
    endcase
  end

  // Payload reads stop once all words are fetched and stall while the output register is held.
  always_comb begin
    rd_req = 1'b0;
    case (rx_state)
      R_HDR:   rd_req = 1'b1;
      R_PAY:   rd_req = (remaining != 16'd0) && (!pl_valid_q || bus.pl_ready);
      R_DROP:  rd_req = 1'b1;
      default: rd_req = 1'b0;
    endcase
  end

  assign bus.fifo_to_copro_out_read = rd_req & ~reset & ~timeout_hit;
  assign bus.res_ready  = (tx_state == T_DATA) & (~write_q | ~bus.fifo_to_hps_in_waitrequest) & ~reset;
  assign bus.cmd_valid  = (rx_state == R_CMD);
  assign bus.cmd_opcode = opcode_q;
  assign bus.cmd_tag    = tag_q;
  assign bus.cmd_len    = len_q;
  assign bus.pl_valid   = pl_valid_q;
  assign bus.pl_data    = pl_data_q;
  assign bus.pl_last    = pl_last_q;
  assign bus.fifo_to_hps_in_write     = write_q;
  assign bus.fifo_to_hps_in_writedata = writedata_q;
  assign bus.status = {16'h0000, cmd_cnt, 3'b000, bad_len, timeout_flag, tx_state, rx_state};

  always_ff @(posedge clk) begin
    if (reset) begin
      opcode_q   <= 8'd0;
      tag_q      <= 8'd0;
      len_q      <= 16'd0;
      remaining  <= 16'd0;
      last_tag   <= 8'd0;
      pl_data_q  <= 32'd0;
      pl_valid_q <= 1'b0;
      pl_last_q  <= 1'b0;
      cmd_cnt    <= 8'd0;
      bad_len    <= 1'b0;
    end else begin
      if (rx_state == R_HDR && rd_done) begin
        opcode_q  <= bus.fifo_to_copro_out_readdata[31:24];
        tag_q     <= bus.fifo_to_copro_out_readdata[23:16];
        len_q     <= bus.fifo_to_copro_out_readdata[15:0];
        remaining <= bus.fifo_to_copro_out_readdata[15:0];
        if (hdr_bad) bad_len <= 1'b1;
      end
      if (cmd_fire) begin
        remaining <= len_q;
        last_tag  <= tag_q;
      end
      if ((rx_state == R_PAY || rx_state == R_DROP) && rd_done)
        remaining <= remaining - 16'd1;
      if (rx_state == R_PAY && rd_done) begin
        pl_data_q  <= bus.fifo_to_copro_out_readdata;
        pl_valid_q <= 1'b1;
        pl_last_q  <= (remaining == 16'd1);
      end else if (pl_fire || timeout_hit) begin
        pl_valid_q <= 1'b0;
        pl_last_q  <= 1'b0;
      end
      if (pl_fire && pl_last_q) cmd_cnt <= cmd_cnt + 8'd1;
    end
  end

  // tx_count == 0 marks the first word of a packet; it is cleared only by the trailer.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_q      <= 1'b0;
      writedata_q  <= 32'd0;
      tx_count     <= 16'd0;
      tx_tag       <= 8'd0;
      trail_issued <= 1'b0;
    end else if (tx_state == T_DATA) begin
      if (res_fire) begin
        writedata_q <= bus.res_data;
        write_q     <= 1'b1;
        if (tx_count != 16'hFFFF) tx_count <= tx_count + 16'd1;
        if (tx_count == 16'd0)    tx_tag   <= last_tag;
      end else if (wr_done) begin
        write_q <= 1'b0;
      end
    end else begin
      if (!trail_issued) begin
        if (!write_q || wr_done) begin
          writedata_q  <= {TRAILER_MAGIC, tx_tag, tx_count};
          write_q      <= 1'b1;
          trail_issued <= 1'b1;
        end
      end else if (wr_done) begin
        write_q      <= 1'b0;
        trail_issued <= 1'b0;
        tx_count     <= 16'd0;
      end
    end
  end
endmodule

// File: tb/tb_copro_fifo_link.sv
// tb/tb_copro_fifo_link.sv - self-checking bench for copro_fifo_link
module tb_copro_fifo_link;
  localparam logic [15:0] MAX_LEN = 16'd4096;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  copro_fifo_link_if bus();

  copro_fifo_link #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(16), .TRAILER_MAGIC(8'hA5)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic [31:0] hdr;
    logic [31:0] base;
    int          pl_mode;
    int          wait_pct;
    bit          tx_after;
    bit          exp_cmd;
    logic [31:0] exp_hdr;
    logic [7:0]  exp_cnt;
    bit          exp_bad;
  } vec_t;

  vec_t vecs[6];

  int tests = 0;
  int fails = 0;

  logic [31:0] rx_q[$];
  logic [31:0] exp_cmd_q[$];
  logic [32:0] exp_pl_q[$];
  logic [32:0] res_q[$];
  logic [31:0] exp_wr_q[$];

  int rx_wait_pct = 0, pl_mode = 0, pat_i = 0, hps_wait_pct = 0;
  int stall_idx = 0, stall_left = 0, wr_cnt = 0, cmd_seen = 0;
  bit cmd_rand = 1'b0, hold_valid = 1'b0;
  logic [31:0] hold_data, last_cmd;
  logic [3:0]  pat = 4'b1001;
  logic [7:0]  cnt_model = 8'd0, tag_model = 8'd0;
  bit          bad_model = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    tests++;
    fails++;
    $display("FAIL %s: actual=%0h expected=none", name, act);
  endtask

  // Reference model: parse a header+payload into the expected cmd and payload streams.
  task automatic push_pkt(input logic [31:0] hdr, input bit rnd, input logic [31:0] base);
    logic [15:0] len;
    logic [31:0] w;
    len = hdr[15:0];
    rx_q.push_back(hdr);
    if (len <= MAX_LEN) begin
      exp_cmd_q.push_back(hdr);
      tag_model = hdr[23:16];
      if (len != 16'd0) cnt_model = cnt_model + 8'd1;
    end else begin
      bad_model = 1'b1;
    end
    for (int j = 0; j < int'(len); j++) begin
      w = rnd ? $urandom : base + 32'(j);
      rx_q.push_back(w);
      if (len <= MAX_LEN) exp_pl_q.push_back({(j == int'(len) - 1), w});
    end
  endtask

  task automatic push_res(input int n, input bit rnd, input logic [31:0] base);
    logic [31:0] w;
    for (int k = 0; k < n; k++) begin
      w = rnd ? $urandom : base + 32'(k);
      res_q.push_back({(k == n - 1), w});
      exp_wr_q.push_back(w);
    end
    exp_wr_q.push_back({8'hA5, tag_model, 16'(n)});
  endtask

  task automatic step();
    logic [31:0] seen;
    logic [31:0] expw;
    logic [32:0] expp;
    @(negedge clk);
    bus.fifo_to_copro_out_waitrequest = (rx_q.size() == 0) || (int'($urandom_range(99)) < rx_wait_pct);
    bus.fifo_to_copro_out_readdata = (rx_q.size() != 0) ? rx_q[0] : 32'h0;
    case (pl_mode)
      0: bus.pl_ready = 1'b1;
      1: begin bus.pl_ready = pat[pat_i]; pat_i = (pat_i + 1) % 4; end
      2: bus.pl_ready = 1'($urandom_range(1));
      default: bus.pl_ready = 1'b0;
    endcase
    bus.cmd_ready = cmd_rand ? 1'($urandom_range(1)) : 1'b1;
    bus.res_valid = (res_q.size() != 0);
    bus.res_data  = (res_q.size() != 0) ? res_q[0][31:0] : 32'h0;
    bus.res_last  = (res_q.size() != 0) ? res_q[0][32] : 1'b0;
    if (stall_left > 0 && bus.fifo_to_hps_in_write && wr_cnt == stall_idx) begin
      bus.fifo_to_hps_in_waitrequest = 1'b1;
      stall_left--;
    end else begin
      bus.fifo_to_hps_in_waitrequest = (int'($urandom_range(99)) < hps_wait_pct);
    end
    #1;
    if (bus.pl_valid && !bus.pl_ready) chk("read_hold", bus.fifo_to_copro_out_read, 0);
    if (bus.fifo_to_copro_out_read && !bus.fifo_to_copro_out_waitrequest) void'(rx_q.pop_front());
    if (bus.cmd_valid && bus.cmd_ready) begin
      seen = {bus.cmd_opcode, bus.cmd_tag, bus.cmd_len};
      cmd_seen++;
      last_cmd = seen;
      if (exp_cmd_q.size() == 0) fail_now("cmd_unexpected", seen);
      else chk("cmd_fields", seen, exp_cmd_q.pop_front());
    end
    if (bus.pl_valid && bus.pl_ready) begin
      if (exp_pl_q.size() == 0) fail_now("pl_unexpected", {bus.pl_last, bus.pl_data});
      else begin
        expp = exp_pl_q.pop_front();
        chk("pl_word", {bus.pl_last, bus.pl_data}, expp);
      end
    end
    if (hold_valid) begin
      chk("wr_hold_req", bus.fifo_to_hps_in_write, 1);
      chk("wr_hold_data", bus.fifo_to_hps_in_writedata, hold_data);
    end
    if (bus.fifo_to_hps_in_write && !bus.fifo_to_hps_in_waitrequest) begin
      if (exp_wr_q.size() == 0) fail_now("wr_unexpected", bus.fifo_to_hps_in_writedata);
      else begin
        expw = exp_wr_q.pop_front();
        chk("wr_data", bus.fifo_to_hps_in_writedata, expw);
      end
      wr_cnt++;
    end
    hold_valid = bus.fifo_to_hps_in_write && bus.fifo_to_hps_in_waitrequest;
    hold_data  = bus.fifo_to_hps_in_writedata;
    if (bus.res_valid && bus.res_ready) void'(res_q.pop_front());
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((rx_q.size() != 0 || exp_cmd_q.size() != 0 || exp_pl_q.size() != 0 ||
            res_q.size() != 0 || exp_wr_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) fail_now({name, "_timeout"}, n);
    step();
    step();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic clear_all();
    rx_q.delete(); exp_cmd_q.delete(); exp_pl_q.delete(); res_q.delete(); exp_wr_q.delete();
    hold_valid = 1'b0;
    cnt_model = 8'd0;
    bad_model = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout: actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h0103_0002, 32'hAAAA_0001, 0, 0,  1'b1, 1'b1, 32'h0103_0002, 8'd1, 1'b0};
    vecs[1] = '{32'h0207_0000, 32'h0,         0, 0,  1'b0, 1'b1, 32'h0207_0000, 8'd1, 1'b0};
    vecs[2] = '{32'h0911_0003, 32'hBBBB_0000, 0, 20, 1'b0, 1'b1, 32'h0911_0003, 8'd2, 1'b0};
    vecs[3] = '{32'h3344_1001, 32'hDEAD_0000, 0, 0,  1'b0, 1'b0, 32'h0,         8'd2, 1'b1};
    vecs[4] = '{32'h0506_0004, 32'h7777_0010, 1, 40, 1'b0, 1'b1, 32'h0506_0004, 8'd3, 1'b1};
    vecs[5] = '{32'h0A0B_1000, 32'h4000_0000, 0, 0,  1'b0, 1'b1, 32'h0A0B_1000, 8'd4, 1'b1};

    reset = 1'b1;
    bus.fifo_to_copro_out_readdata = 32'h0;
    bus.fifo_to_copro_out_waitrequest = 1'b1;
    bus.fifo_to_hps_in_waitrequest = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.pl_ready = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_data = 32'h0;
    bus.res_last = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_read", bus.fifo_to_copro_out_read, 0);
    chk("rst_write", bus.fifo_to_hps_in_write, 0);
    chk("rst_res_ready", bus.res_ready, 0);
    chk("rst_cmd", {bus.cmd_valid, bus.cmd_opcode, bus.cmd_tag, bus.cmd_len}, 0);
    chk("rst_pl", {bus.pl_valid, bus.pl_last, bus.pl_data}, 0);
    chk("rst_writedata", bus.fifo_to_hps_in_writedata, 0);
    chk("rst_status", bus.status, 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      int seen0;
      seen0 = cmd_seen;
      rx_wait_pct = vecs[i].wait_pct;
      pl_mode = vecs[i].pl_mode;
      pat_i = 0;
      push_pkt(vecs[i].hdr, 1'b0, vecs[i].base);
      drain($sformatf("vec%0d", i), 20000);
      chk($sformatf("vec%0d_ncmd", i), cmd_seen - seen0, vecs[i].exp_cmd);
      if (vecs[i].exp_cmd) chk($sformatf("vec%0d_hdr", i), last_cmd, vecs[i].exp_hdr);
      if (vecs[i].tx_after) begin
        wr_cnt = 0;
        stall_idx = 1;
        stall_left = 5;
        hps_wait_pct = 0;
        push_res(3, 1'b0, 32'hC0DE_0000);
        drain("tx_seq", 200);
        chk("tx_stall_applied", stall_left, 0);
      end
      chk($sformatf("vec%0d_status", i), bus.status,
          {16'h0, vecs[i].exp_cnt, 3'b000, vecs[i].exp_bad, 4'b0000});
    end

    rx_wait_pct = 30;
    pl_mode = 2;
    cmd_rand = 1'b1;
    for (int i = 0; i < 20; i++)
      push_pkt({8'($urandom_range(255)), 8'($urandom_range(255)), 16'($urandom_range(6))}, 1'b1, 32'h0);
    drain("rand_rx", 5000);
    chk("rand_rx_status", bus.status, {16'h0, cnt_model, 3'b000, bad_model, 4'b0000});
    hps_wait_pct = 30;
    stall_left = 0;
    for (int i = 0; i < 5; i++) push_res(int'($urandom_range(5, 1)), 1'b1, 32'h0);
    drain("rand_tx", 2000);
    chk("rand_tx_status", bus.status, {16'h0, cnt_model, 3'b000, bad_model, 4'b0000});

    pl_mode = 3;
    rx_wait_pct = 0;
    hps_wait_pct = 0;
    cmd_rand = 1'b0;
    rx_q.push_back(32'h0C0D_0003);
    rx_q.push_back(32'h1234_5678);
    exp_cmd_q.push_back(32'h0C0D_0003);
    repeat (6) step();
    chk("midop_pl_valid", bus.pl_valid, 1);
    chk("midop_rx_state", bus.status[1:0], 2);
    pulse_reset();
    chk("midop_rst_status", bus.status, 0);
    chk("midop_rst_outputs", {bus.pl_valid, bus.cmd_valid, bus.fifo_to_copro_out_read}, 0);
    reset = 1'b0;
    clear_all();
    pl_mode = 0;
    push_pkt(32'h0E0F_0001, 1'b0, 32'h55AA_0000);
    drain("recover", 200);
    chk("recover_status", bus.status, {16'h0, 8'd1, 8'h00});

`ifdef COPRO_LINK_TIMEOUT_EN
    rx_q.push_back(32'h0102_0004);
    exp_cmd_q.push_back(32'h0102_0004);
    repeat (40) step();
    chk("wd_flag", bus.status[3], 1);
    chk("wd_rx_state", bus.status[1:0], 0);
    chk("wd_pl_valid", bus.pl_valid, 0);
    pulse_reset();
    chk("wd_rst_status", bus.status, 0);
    reset = 1'b0;
    clear_all();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
